// File: rtl/spi_pkg.sv
// Shared SPI definitions: master defaults plus the slave FSM encoding and
// slave parameter defaults.
package spi_pkg;

  // SPI master defaults.
  localparam int SPI_MST_NBITS_DEF   = 24;
  localparam int SPI_MST_CLK_DIV_DEF = 4;
  localparam bit SPI_MST_CPOL        = 1'b0;
  localparam bit SPI_MST_CPHA        = 1'b0;

  // SPI slave defaults.
  localparam int SPI_SLV_NBITS_DEF = 24;
  localparam int SPI_SLV_NSYNC_DEF = 2;

  // Slave transaction state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_slv_state_e;

  // Increment an 8-bit counter, holding at its maximum.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input into the aclk domain.
module spi_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic aclk,
  input  logic areset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  // Register the chain; reset to the line's idle level.
  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: the chain resets to the idle level of the line so that leaving
    // reset never looks like an edge on the synchronized signal.
    if (areset) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/axi4lite_spi_slave.sv
// SPI mode-0 slave oversampled by aclk: receives an NBITS word on mosi,
// returns spi_tx_din on miso, and keeps word and abort statistics.
module axi4lite_spi_slave
  import spi_pkg::*;
#(
  parameter int NBITS = SPI_SLV_NBITS_DEF,
  parameter int NSYNC = SPI_SLV_NSYNC_DEF
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] spi_tx_din,
  output logic [31:0] spi_rx_dout,
  output logic        spi_rx_vld,
  output logic        spi_busy,
  output logic [31:0] spi_event_count,
  output logic [7:0]  spi_abort_count,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe
);

  localparam int CNT_W = $clog2(NBITS + 1);

  // Synchronized SPI inputs.
  logic cs_s;
  logic sclk_s;
  logic mosi_s;

  spi_sync #(.DEPTH(NSYNC), .RST_VAL(1'b1)) u_sync_cs (
    .aclk(aclk), .areset(areset), .d(cs_n), .q(cs_s)
  );
  spi_sync #(.DEPTH(NSYNC), .RST_VAL(1'b0)) u_sync_sclk (
    .aclk(aclk), .areset(areset), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.DEPTH(NSYNC), .RST_VAL(1'b0)) u_sync_mosi (
    .aclk(aclk), .areset(areset), .d(mosi), .q(mosi_s)
  );

  // Upper tx bits beyond NBITS are intentionally ignored.
  logic unused_tx_bits;
  assign unused_tx_bits = ^spi_tx_din;

  spi_slv_state_e   state_q,     state_d;
  logic [NBITS-1:0] tx_sr_q,     tx_sr_d;
  logic [NBITS-1:0] rx_sr_q,     rx_sr_d;
  logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [31:0]      rx_dout_q,   rx_dout_d;
  logic             rx_vld_q,    rx_vld_d;
  logic             busy_q,      busy_d;
  logic [31:0]      event_cnt_q, event_cnt_d;
  logic [7:0]       abort_cnt_q, abort_cnt_d;
  logic             miso_q,      miso_d;
  logic             miso_oe_q,   miso_oe_d;
  logic             cs_prev_q,   cs_prev_d;
  logic             sclk_prev_q, sclk_prev_d;
  // flush_q fills with ones after reset; its top bit marks the point where
  // the synchronizer outputs reflect the real pins rather than reset values.
  logic [NSYNC:0]   flush_q,     flush_d;
  // armed_q is set once cs_n has been seen high after reset, so a select
  // held low across reset cannot start a transaction.
  logic             armed_q,     armed_d;

  logic cs_fall;
  logic cs_rise;
  logic sclk_rise;
  logic sclk_fall;

  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // Next-state logic for the transaction FSM, shift registers and counters.
  always_comb begin
    // NOTE: every _d signal starts from a default so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    rx_dout_d   = rx_dout_q;
    rx_vld_d    = 1'b0;
    busy_d      = busy_q;
    event_cnt_d = event_cnt_q;
    abort_cnt_d = abort_cnt_q;
    miso_d      = miso_q;
    miso_oe_d   = ~cs_s;
    cs_prev_d   = cs_s;
    sclk_prev_d = sclk_s;
    flush_d     = {flush_q[NSYNC-1:0], 1'b1};
    armed_d     = armed_q | (flush_q[NSYNC] & cs_s);

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = ST_SHIFT;
          tx_sr_d   = spi_tx_din[NBITS-1:0];
          rx_sr_d   = '0;
          miso_d    = spi_tx_din[NBITS-1];
          bit_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          // Truncated transaction: drop the partial word.
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          miso_d      = 1'b0;
          abort_cnt_d = sat_inc8(abort_cnt_q);
        end else if (sclk_rise) begin
          rx_sr_d   = (rx_sr_q << 1) | NBITS'(mosi_s);
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_d == CNT_W'(NBITS)) begin
            state_d     = ST_DONE;
            rx_dout_d   = 32'(rx_sr_d);
            rx_vld_d    = 1'b1;
            event_cnt_d = event_cnt_q + 32'd1;
            miso_d      = 1'b0;
          end
        end else if (sclk_fall) begin
          // Zeros shift in behind the word, so miso reads 0 once it is spent.
          tx_sr_d = tx_sr_q << 1;
          miso_d  = tx_sr_d[NBITS-1];
        end
      end

      ST_DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        miso_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      rx_dout_q   <= '0;
      rx_vld_q    <= 1'b0;
      busy_q      <= 1'b0;
      event_cnt_q <= '0;
      abort_cnt_q <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_dout_q   <= rx_dout_d;
      rx_vld_q    <= rx_vld_d;
      busy_q      <= busy_d;
      event_cnt_q <= event_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  assign spi_rx_dout     = rx_dout_q;
  assign spi_rx_vld      = rx_vld_q;
  assign spi_busy        = busy_q;
  assign spi_event_count = event_cnt_q;
  assign spi_abort_count = abort_cnt_q;
  assign miso            = miso_q;
  assign miso_oe         = miso_oe_q;

endmodule

// File: doc/axi4lite_spi_slave.md
AXI4LITE_SPI_SLAVE -- requirements
Module: axi4lite_spi_slave

Interface
REQ-001 SHALL have parameter NBITS, default 24, SPI word length in bits (1..32).
REQ-002 SHALL have parameter NSYNC, default 2, synchronizer flops on each SPI input (>=2).
REQ-003 SHALL have port aclk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port spi_tx_din, input, 32, word to return on miso; bits [NBITS-1:0] are used.
REQ-006 SHALL have port spi_rx_dout, output, 32, last complete received word, zero-extended above NBITS.
REQ-007 SHALL have port spi_rx_vld, output, 1, one-cycle pulse when spi_rx_dout updates.
REQ-008 SHALL have port spi_busy, output, 1, high while a transaction is in progress.
REQ-009 SHALL have port spi_event_count, output, 32, count of complete words received, wraps.
REQ-010 SHALL have port spi_abort_count, output, 8, count of truncated transactions, saturating at 255.
REQ-011 SHALL have port cs_n, input, 1, active-low chip select from the external master.
REQ-012 SHALL have port sclk, input, 1, external SPI clock; mode 0 (CPOL=0, CPHA=0).
REQ-013 SHALL have ports mosi, input, 1, and miso, output, 1, serial data MSB first.
REQ-014 SHALL have port miso_oe, output, 1, high while cs_n is low (sync), for a tri-state pad.

Function
REQ-015 SHALL pass cs_n, sclk and mosi through NSYNC-flop synchronizers plus one history flop for edge detection; aclk frequency SHALL be >= 8x sclk.
REQ-016 SHALL implement states IDLE, SHIFT, DONE.
REQ-017 IDLE->SHIFT on synchronized cs_n falling edge: load tx shift register from spi_tx_din[NBITS-1:0], drive miso = bit NBITS-1, clear bit counter, assert spi_busy.
REQ-018 In SHIFT, a detected sclk rising edge SHALL shift synchronized mosi into rx shift register LSB and increment the bit counter.
REQ-019 In SHIFT, a detected sclk falling edge SHALL advance miso to the next tx bit; after the last bit miso SHALL be 0.
REQ-020 When the bit counter reaches NBITS, SHALL go to DONE, update spi_rx_dout, pulse spi_rx_vld for exactly one cycle and increment spi_event_count, all in the same cycle.
REQ-021 DONE SHALL ignore further sclk edges; miso stays 0; no second word is captured within one cs_n assertion.
REQ-022 cs_n rising (sync) in DONE SHALL return to IDLE with no other effect.
REQ-023 cs_n rising (sync) in SHIFT SHALL return to IDLE, leave spi_rx_dout and spi_event_count unchanged, no spi_rx_vld, and increment spi_abort_count unless 255.
REQ-024 sclk edges while cs_n is high SHALL be ignored.
REQ-025 spi_tx_din changes after the cs_n falling edge SHALL NOT affect the word in flight.
REQ-026 spi_rx_vld SHALL occur NSYNC+2 aclk cycles after the external sclk edge that delivers bit NBITS, +-1 cycle for input phase.
REQ-027 spi_busy SHALL be high in SHIFT and DONE, low in IDLE.

Reset
REQ-028 areset SHALL asynchronously force IDLE, spi_rx_dout=0, spi_rx_vld=0, spi_busy=0, spi_event_count=0, spi_abort_count=0, miso=0, miso_oe=0, synchronizer flops to idle levels (cs_n=1, sclk=0, mosi=0).
REQ-029 Reset asserted mid-transaction SHALL discard it without counting an abort; after release, a cs_n still low SHALL NOT start a transaction until a fresh falling edge.

Structure
REQ-030 State encoding and default NBITS/NSYNC SHALL live in shared package spi_pkg, alongside the existing SPI master constants.
REQ-031 Synchronizer SHALL be a sub-module spi_sync (parameterised depth and reset value), instantiated three times.

Verification
REQ-032 NBITS=24, tx=0xA5C3F0, master sends 0x123456 -> spi_rx_dout=0x00123456, one spi_rx_vld, master reads 0xA5C3F0, event_count=1.
REQ-033 cs_n deasserted after 10 sclk cycles -> abort_count=1, spi_rx_dout and event_count unchanged, no vld.
REQ-034 30 sclk cycles in one cs_n window, NBITS=24 -> one word captured, miso 0 for bits 25..30, event_count +1.
REQ-035 spi_tx_din changed to 0xFFFFFF at bit 5 -> master still reads original word.
REQ-036 areset pulsed at bit 12 with cs_n held low -> all outputs reset, abort_count=0; next cs_n cycle completes normally.
REQ-037 event_count preloaded via 2^32-1 transfers (forced) + one transfer -> wraps to 0; 260 aborts -> abort_count=255.
